// File: rtl/data_memory_arbiter_if.sv
// Bundle of the two requester ports and the single-port data memory port.
// slave: the arbiter's view; master: the requesters plus memory.
interface data_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  done0;
    logic                  done1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  err0;
    logic                  err1;
    logic [ADDR_WIDTH-1:0] mem_adress;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
               mem_adress, mem_write_data, mem_write, mem_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
               mem_adress, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory (IDLE->ACCESS->DONE).
// Optional range check on the granted address: define DMEM_ARB_RANGE_CHECK_EN.
module data_memory_arbiter #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input logic                  clk,
    input logic                  rst_n,
    data_memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state, state_nxt;
    logic                  last, last_nxt;
    logic                  winner, winner_nxt;
    logic                  lat_we, lat_we_nxt;
    logic                  lat_oor, lat_oor_nxt;
    logic                  gnt0_q, gnt0_nxt, gnt1_q, gnt1_nxt;
    logic                  done0_q, done0_nxt, done1_q, done1_nxt;
    logic                  mem_write_q, mem_write_nxt, mem_read_q, mem_read_nxt;
    logic [ADDR_WIDTH-1:0] mem_adress_q, mem_adress_nxt;
    logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_nxt;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_nxt, rdata1_q, rdata1_nxt;
    logic [DATA_WIDTH-1:0] rd_value;

    logic                  sel;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_oor;

    // Both requesting: the port opposite the last completed one wins.
    assign sel       = (bus.req0 & bus.req1) ? ~last : bus.req1;
    assign sel_we    = sel ? bus.we1    : bus.we0;
    assign sel_addr  = sel ? bus.addr1  : bus.addr0;
    assign sel_wdata = sel ? bus.wdata1 : bus.wdata0;

    assign rd_value  = lat_oor ? '0 : bus.mem_read_data;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        last_nxt           = last;
        winner_nxt         = winner;
        lat_we_nxt         = lat_we;
        lat_oor_nxt        = lat_oor;
        gnt0_nxt           = 1'b0;
        gnt1_nxt           = 1'b0;
        done0_nxt          = 1'b0;
        done1_nxt          = 1'b0;
        mem_write_nxt      = 1'b0;
        mem_read_nxt       = 1'b0;
        mem_adress_nxt     = mem_adress_q;
        mem_write_data_nxt = mem_write_data_q;
        rdata0_nxt         = rdata0_q;
        rdata1_nxt         = rdata1_q;
        unique case (state)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    state_nxt          = ACCESS;
                    winner_nxt         = sel;
                    lat_we_nxt         = sel_we;
                    lat_oor_nxt        = sel_oor;
                    gnt0_nxt           = ~sel;
                    gnt1_nxt           = sel;
                    mem_adress_nxt     = sel_addr;
                    mem_write_data_nxt = sel_wdata;
                    mem_write_nxt      = sel_we & ~sel_oor;
                    mem_read_nxt       = ~sel_we & ~sel_oor;
                end
            end
            ACCESS: begin
                // Strobes were registered on entry; this edge closes the access.
                state_nxt = DONE;
                last_nxt  = winner;
                done0_nxt = ~winner;
                done1_nxt = winner;
                if (!lat_we) begin
                    if (winner) rdata1_nxt = rd_value;
                    else        rdata0_nxt = rd_value;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last             <= 1'b1;
            winner           <= 1'b0;
            lat_we           <= 1'b0;
            lat_oor          <= 1'b0;
            gnt0_q           <= 1'b0;
            gnt1_q           <= 1'b0;
            done0_q          <= 1'b0;
            done1_q          <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_adress_q     <= '0;
            mem_write_data_q <= '0;
            rdata0_q         <= '0;
            rdata1_q         <= '0;
        end else begin
            last             <= last_nxt;
            winner           <= winner_nxt;
            lat_we           <= lat_we_nxt;
            lat_oor          <= lat_oor_nxt;
            gnt0_q           <= gnt0_nxt;
            gnt1_q           <= gnt1_nxt;
            done0_q          <= done0_nxt;
            done1_q          <= done1_nxt;
            mem_write_q      <= mem_write_nxt;
            mem_read_q       <= mem_read_nxt;
            mem_adress_q     <= mem_adress_nxt;
            mem_write_data_q <= mem_write_data_nxt;
            rdata0_q         <= rdata0_nxt;
            rdata1_q         <= rdata1_nxt;
        end
    end

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    logic err0_q, err1_q;

    assign sel_oor = ({1'b0, sel_addr} >= DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            err0_q <= (state == ACCESS) & lat_oor & ~winner;
            err1_q <= (state == ACCESS) & lat_oor & winner;
        end
    end

    assign bus.err0 = err0_q;
    assign bus.err1 = err1_q;
`else
    assign sel_oor  = 1'b0;
    assign bus.err0 = 1'b0;
    assign bus.err1 = 1'b0;
`endif

    assign bus.gnt0           = gnt0_q;
    assign bus.gnt1           = gnt1_q;
    assign bus.done0          = done0_q;
    assign bus.done1          = done1_q;
    assign bus.rdata0         = rdata0_q;
    assign bus.rdata1         = rdata1_q;
    assign bus.mem_adress     = mem_adress_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_read       = mem_read_q;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a small combinational-read memory model.
module tb_data_memory_arbiter;
    localparam int AW = 18;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [DW-1:0] mem [0:255];

    data_memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_read_data = !bus.mem_read ? '0 :
                               (bus.mem_adress < 18'd256) ? mem[bus.mem_adress[7:0]] : 32'hBADC0DE5;

    always @(posedge clk) begin
        if (bus.mem_write && bus.mem_adress < 18'd256) mem[bus.mem_adress[7:0]] <= bus.mem_write_data;
    end

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b0) begin errors++; $display("FAIL rst_gnt_done got %b exp 0000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1}); end
        checks++; if ({bus.err0, bus.err1, bus.mem_write, bus.mem_read} !== 4'b0) begin errors++; $display("FAIL rst_err_strobe got %b exp 0000", {bus.err0, bus.err1, bus.mem_write, bus.mem_read}); end
        checks++; if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", bus.rdata0, bus.rdata1); end
        checks++; if (bus.mem_adress !== 18'h0 || bus.mem_write_data !== 32'h0) begin errors++; $display("FAIL rst_membus got %h/%h exp 0/0", bus.mem_adress, bus.mem_write_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({bus.gnt0, bus.gnt1, bus.mem_read, bus.mem_write} !== 4'b0) begin errors++; $display("FAIL idle_noreq got %b exp 0000", {bus.gnt0, bus.gnt1, bus.mem_read, bus.mem_write}); end
    endtask

    task automatic test_single_read();
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 18'd5;
        @(negedge clk);
        checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL rd_gnt got %b%b exp 10", bus.gnt0, bus.gnt1); end
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL rd_strobe got r%b w%b exp r1 w0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_adress !== 18'd5) begin errors++; $display("FAIL rd_addr got %0d exp 5", bus.mem_adress); end
        checks++; if (bus.done0 !== 1'b0) begin errors++; $display("FAIL rd_early_done got %b exp 0", bus.done0); end
        bus.req0 = 1'b0;
        @(negedge clk);
        checks++; if (bus.done0 !== 1'b1 || bus.done1 !== 1'b0) begin errors++; $display("FAIL rd_done got %b%b exp 10", bus.done0, bus.done1); end
        checks++; if (bus.rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata0 got %h exp deadbeef", bus.rdata0); end
        checks++; if (bus.rdata1 !== 32'h0 || bus.gnt1 !== 1'b0 || bus.err1 !== 1'b0) begin errors++; $display("FAIL rd_port1_quiet got %h/%b/%b exp 0/0/0", bus.rdata1, bus.gnt1, bus.err1); end
        checks++; if ({bus.gnt0, bus.mem_read, bus.mem_write} !== 3'b0) begin errors++; $display("FAIL rd_done_strobes got %b exp 000", {bus.gnt0, bus.mem_read, bus.mem_write}); end
        @(negedge clk);
        checks++; if (bus.done0 !== 1'b0 || bus.rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_after got %b/%h exp 0/deadbeef", bus.done0, bus.rdata0); end
    endtask

    task automatic test_write_readback();
        do_reset();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 18'd9; bus.wdata1 = 32'h12345678;
        @(negedge clk);
        checks++; if (bus.gnt1 !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL wr_access got g%b w%b r%b exp g1 w1 r0", bus.gnt1, bus.mem_write, bus.mem_read); end
        checks++; if (bus.mem_adress !== 18'd9 || bus.mem_write_data !== 32'h12345678) begin errors++; $display("FAIL wr_bus got %0d/%h exp 9/12345678", bus.mem_adress, bus.mem_write_data); end
        bus.req1 = 1'b0; bus.wdata1 = 32'hFFFFFFFF;
        @(negedge clk);
        checks++; if (bus.mem_write !== 1'b0 || bus.done1 !== 1'b1 || bus.done0 !== 1'b0) begin errors++; $display("FAIL wr_done got w%b d1%b d0%b exp w0 d1 1 d0 0", bus.mem_write, bus.done1, bus.done0); end
        checks++; if (bus.rdata1 !== 32'h0) begin errors++; $display("FAIL wr_rdata1_hold got %h exp 0", bus.rdata1); end
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 18'd9;
        @(negedge clk);
        checks++; if (bus.gnt0 !== 1'b1 || bus.mem_read !== 1'b1) begin errors++; $display("FAIL wrrb_gnt got g%b r%b exp g1 r1", bus.gnt0, bus.mem_read); end
        bus.req0 = 1'b0;
        @(negedge clk);
        checks++; if (bus.done0 !== 1'b1 || bus.rdata0 !== 32'h12345678) begin errors++; $display("FAIL wrrb_rdata got %b/%h exp 1/12345678", bus.done0, bus.rdata0); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        idle_inputs();
        bus.req0 = 1'b1; bus.addr0 = 18'd1;
        bus.req1 = 1'b1; bus.addr1 = 18'd2;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (bus.gnt0 !== (i % 6 == 0) || bus.gnt1 !== (i % 6 == 3)) begin errors++; $display("FAIL cont_gnt[%0d] got %b%b exp %b%b", i, bus.gnt0, bus.gnt1, (i % 6 == 0), (i % 6 == 3)); end
            checks++; if (bus.done0 !== (i % 6 == 1) || bus.done1 !== (i % 6 == 4)) begin errors++; $display("FAIL cont_done[%0d] got %b%b exp %b%b", i, bus.done0, bus.done1, (i % 6 == 1), (i % 6 == 4)); end
            checks++; if ((bus.mem_read & bus.mem_write) !== 1'b0 || bus.mem_read !== (i % 3 == 0)) begin errors++; $display("FAIL cont_strobe[%0d] got r%b w%b exp r%b w0", i, bus.mem_read, bus.mem_write, (i % 3 == 0)); end
        end
        checks++; if (bus.rdata0 !== 32'h11111111 || bus.rdata1 !== 32'h22222222) begin errors++; $display("FAIL cont_rdata got %h/%h exp 11111111/22222222", bus.rdata0, bus.rdata1); end
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 18'd3;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (bus.gnt1 !== (i % 3 == 0) || bus.gnt0 !== 1'b0) begin errors++; $display("FAIL b2b_gnt[%0d] got %b%b exp 0%b", i, bus.gnt0, bus.gnt1, (i % 3 == 0)); end
            checks++; if (bus.done1 !== (i % 3 == 1) || bus.done0 !== 1'b0) begin errors++; $display("FAIL b2b_done[%0d] got %b%b exp 0%b", i, bus.done0, bus.done1, (i % 3 == 1)); end
        end
        checks++; if (bus.rdata1 !== 32'h33333333) begin errors++; $display("FAIL b2b_rdata1 got %h exp 33333333", bus.rdata1); end
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 18'd7; bus.wdata0 = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (bus.gnt0 !== 1'b1 || bus.mem_write !== 1'b1) begin errors++; $display("FAIL rm_access got g%b w%b exp g1 w1", bus.gnt0, bus.mem_write); end
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        checks++; if ({bus.gnt0, bus.mem_write, bus.mem_read, bus.done0} !== 4'b0) begin errors++; $display("FAIL rm_abort got %b exp 0000", {bus.gnt0, bus.mem_write, bus.mem_read, bus.done0}); end
        checks++; if (bus.mem_adress !== 18'h0 || bus.mem_write_data !== 32'h0) begin errors++; $display("FAIL rm_membus got %h/%h exp 0/0", bus.mem_adress, bus.mem_write_data); end
        @(negedge clk);
        checks++; if (bus.done0 !== 1'b0) begin errors++; $display("FAIL rm_nodone got %b exp 0", bus.done0); end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 18'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 18'd2;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.done0 !== 1'b0) begin errors++; $display("FAIL rm_first_gnt got g%b%b d%b exp g10 d0", bus.gnt0, bus.gnt1, bus.done0); end
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_range();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 18'd5;
        @(negedge clk);
        bus.req0 = 1'b0;
        @(negedge clk);
        checks++; if (bus.rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rng_pre got %h exp deadbeef", bus.rdata0); end
        @(negedge clk);
        bus.req0 = 1'b1; bus.addr0 = 18'd300;
        @(negedge clk);
        bus.req0 = 1'b0;
        checks++; if (bus.gnt0 !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL rng_gnt got g%b w%b exp g1 w0", bus.gnt0, bus.mem_write); end
`ifdef DMEM_ARB_RANGE_CHECK_EN
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL rng_read got %b exp 0", bus.mem_read); end
        @(negedge clk);
        checks++; if (bus.done0 !== 1'b1 || bus.err0 !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL rng_done got d%b e%b r%b exp d1 e1 r0", bus.done0, bus.err0, bus.mem_read); end
        checks++; if (bus.rdata0 !== 32'h0 || bus.err1 !== 1'b0) begin errors++; $display("FAIL rng_rdata got %h/%b exp 0/0", bus.rdata0, bus.err1); end
        @(negedge clk);
        checks++; if (bus.err0 !== 1'b0) begin errors++; $display("FAIL rng_err_clear got %b exp 0", bus.err0); end
`else
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_adress !== 18'd300) begin errors++; $display("FAIL rng_read got r%b a%0d exp r1 a300", bus.mem_read, bus.mem_adress); end
        @(negedge clk);
        checks++; if (bus.done0 !== 1'b1 || bus.err0 !== 1'b0) begin errors++; $display("FAIL rng_done got d%b e%b exp d1 e0", bus.done0, bus.err0); end
        checks++; if (bus.rdata0 !== 32'hBADC0DE5) begin errors++; $display("FAIL rng_rdata got %h exp badc0de5", bus.rdata0); end
        @(negedge clk);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 + 32'(i);
        mem[1] = 32'h11111111;
        mem[2] = 32'h22222222;
        mem[3] = 32'h33333333;
        mem[5] = 32'hDEADBEEF;
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
